// File: rtl/acsi_io_bridge.sv
`default_nettype none
// ============================================================================
// acsi_io_bridge: captures an 11-byte ACSI command on busy, streams it to the
// IO controller and reports completion; ACSI_IO_BRIDGE_TIMEOUT_EN adds a
// response timeout. Revision: 1.0
// ============================================================================
module acsi_io_bridge #(
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] acsi_status_sel,
  input  logic [7:0] acsi_status_byte,
  output logic [7:0] io_data,
  output logic       io_valid,
  input  logic       io_ready,
  input  logic       io_rsp_valid,
  input  logic       io_rsp_ok,
  input  logic [7:0] io_rsp_status,
  output logic       dma_ack,
  output logic       dma_nak,
  output logic [7:0] dma_status,
  output logic       idle
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4,
    S_SETTLE  = 3'd5
  } state_t;

  localparam logic [3:0] SEL_BUSY       = 4'd10;
  localparam logic [3:0] LAST_IDX       = 4'd10;
  localparam logic [7:0] TIMEOUT_STATUS = 8'h02;

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] idx_q, idx_d;
  logic       settle_q, settle_d;
  logic       io_valid_q, io_valid_d;
  logic       ack_q, ack_d;
  logic       nak_q, nak_d;
  logic [7:0] status_q, status_d;
  logic [7:0] buf_q [0:10];
  logic [7:0] buf_d [0:10];
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    io_valid_d = 1'b0;
    ack_d      = 1'b0;
    nak_d      = 1'b0;
    status_d   = status_q;
    buf_d      = buf_q;
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        sel_d = SEL_BUSY;
        if (acsi_status_byte[0]) begin
          state_d = S_CAPTURE;
          sel_d   = 4'd0;
          idx_d   = 4'd0;
        end
      end
      S_CAPTURE: begin
        // sel_q already points at idx_q, so the readout byte belongs here
        buf_d[idx_q] = acsi_status_byte;
        if (idx_q == LAST_IDX) begin
          state_d    = S_SEND;
          idx_d      = 4'd0;
          sel_d      = SEL_BUSY;
          io_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          sel_d = idx_q + 4'd1;
        end
      end
      S_SEND: begin
        io_valid_d = 1'b1;
        if (io_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_WAIT;
            io_valid_d = 1'b0;
            idx_d      = 4'd0;
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
            tmo_d      = '0;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (io_rsp_valid) begin
          state_d  = S_DONE;
          ack_d    = io_rsp_ok;
          nak_d    = !io_rsp_ok;
          status_d = io_rsp_status;
        end
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
        else if (&tmo_q) begin
          state_d  = S_DONE;
          nak_d    = 1'b1;
          status_d = TIMEOUT_STATUS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d  = S_SETTLE;
        settle_d = 1'b0;
      end
      S_SETTLE: begin
        // busy is deliberately not looked at here; it may still be stale
        if (settle_q) begin
          state_d  = S_IDLE;
          settle_d = 1'b0;
        end else begin
          settle_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= SEL_BUSY;
      idx_q      <= 4'd0;
      settle_q   <= 1'b0;
      io_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      nak_q      <= 1'b0;
      status_q   <= 8'h00;
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      io_valid_q <= io_valid_d;
      ack_q      <= ack_d;
      nak_q      <= nak_d;
      status_q   <= status_d;
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign acsi_status_sel = sel_q;
  assign io_data         = buf_q[idx_q];
  assign io_valid        = io_valid_q;
  assign dma_ack         = ack_q;
  assign dma_nak         = nak_q;
  assign dma_status      = status_q;
  assign idle            = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acsi_io_bridge.sv
`default_nettype none
// ============================================================================
// tb_acsi_io_bridge: randomized scoreboard bench for acsi_io_bridge.
// Revision: 1.0
// ============================================================================
module tb_acsi_io_bridge;

  localparam int TW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] acsi_status_sel;
  logic [7:0] acsi_status_byte;
  logic [7:0] io_data;
  logic       io_valid;
  logic       io_ready;
  logic       io_rsp_valid;
  logic       io_rsp_ok;
  logic [7:0] io_rsp_status;
  logic       dma_ack;
  logic       dma_nak;
  logic [7:0] dma_status;
  logic       idle;

  logic [7:0] mem [16];
  assign acsi_status_byte = mem[acsi_status_sel];

  acsi_io_bridge #(.TIMEOUT_W(TW)) dut (
    .clk              (clk),
    .reset            (reset),
    .acsi_status_sel  (acsi_status_sel),
    .acsi_status_byte (acsi_status_byte),
    .io_data          (io_data),
    .io_valid         (io_valid),
    .io_ready         (io_ready),
    .io_rsp_valid     (io_rsp_valid),
    .io_rsp_ok        (io_rsp_ok),
    .io_rsp_status    (io_rsp_status),
    .dma_ack          (dma_ack),
    .dma_nak          (dma_nak),
    .dma_status       (dma_status),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ok;
    logic [7:0] st;
    int         at;
  } cmp_t;

  logic [7:0] exp_bytes [$];
  int         exp_first [$];
  cmp_t       exp_cmp   [$];
  logic [7:0] last_st = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  logic prev_v = 1'b0;
  int   mon_e;
  cmp_t mon_c;
  always @(negedge clk) begin
    if (!reset) begin
      if (io_valid && !prev_v) begin
        if (exp_first.size() == 0) check("spurious_io_valid", 32'd1, 32'd0);
        else begin
          mon_e = exp_first.pop_front();
          check("first_valid_cycle", cyc, mon_e);
        end
      end
      if (io_valid && io_ready) begin
        if (exp_bytes.size() == 0) check("extra_byte", 32'd1, 32'd0);
        else check("io_data", {24'd0, io_data}, {24'd0, exp_bytes.pop_front()});
      end else if (io_valid && exp_bytes.size() > 0) begin
        check("hold_data", {24'd0, io_data}, {24'd0, exp_bytes[0]});
      end
      if (dma_ack || dma_nak) begin
        if (exp_cmp.size() == 0) check("spurious_done", {30'd0, dma_ack, dma_nak}, 32'd0);
        else begin
          mon_c = exp_cmp.pop_front();
          check("dma_ack", {31'd0, dma_ack}, {31'd0, mon_c.ok});
          check("dma_nak", {31'd0, dma_nak}, {31'd0, !mon_c.ok});
          check("dma_status", {24'd0, dma_status}, {24'd0, mon_c.st});
          check("done_cycle", cyc, mon_c.at);
        end
      end
    end
    prev_v <= reset ? 1'b0 : io_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    if (!idle) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Presents a new command; the DUT sees busy in IDLE 'delta' cycles from now.
  task automatic start_capture(input int delta, input bit fixed);
    logic [7:0] pat [10] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] b [11];
    logic [2:0] tgt;
    tgt = 3'($urandom_range(0, 7));
    for (int i = 0; i < 10; i++) b[i] = fixed ? pat[i] : 8'($urandom);
    b[10] = {tgt, 4'b0000, 1'b1};
    for (int i = 0; i < 11; i++) begin
      mem[i] = b[i];
      exp_bytes.push_back(b[i]);
    end
    exp_first.push_back(cyc + delta + 12);
  endtask

  // Drives io_ready until the command has been streamed; returns in the first WAIT cycle.
  task automatic send_phase(input int rmode);
    bit seen = 0;
    int n = 0;
    while (n < 300) begin
      case (rmode)
        0:       io_ready = 1'b1;
        1:       io_ready = (cyc % 2 == 0);
        default: io_ready = 1'($urandom_range(0, 1));
      endcase
      io_rsp_valid  = (n == 3);
      io_rsp_ok     = 1'b1;
      io_rsp_status = 8'h5A;
      if (io_valid) seen = 1;
      else if (seen) break;
      tick();
      n++;
    end
    io_rsp_valid = 1'b0;
    if (n >= 300) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic respond(input int dly, input bit ok, input logic [7:0] st);
    cmp_t c;
    repeat (dly) tick();
    io_rsp_valid  = 1'b1;
    io_rsp_ok     = ok;
    io_rsp_status = st;
    c.ok = ok; c.st = st; c.at = cyc + 1;
    exp_cmp.push_back(c);
    last_st = st;
    tick();
    io_rsp_valid = 1'b0;
  endtask

  // post: 0 drop busy at once, 1 leave busy stale through SETTLE, 2 chain a new command
  task automatic run_cmd(input bit chained, input bit fixed, input int rmode,
                         input bit ok, input logic [7:0] st, input int dly, input int post);
    if (!chained) begin
      wait_idle();
      check("status_hold", {24'd0, dma_status}, {24'd0, last_st});
      start_capture(0, fixed);
    end
    send_phase(rmode);
    respond(dly, ok, st);
    case (post)
      0: mem[10][0] = 1'b0;
      1: begin
        repeat (3) tick();
        mem[10][0] = 1'b0;
        repeat (14) tick();
        check("no_recapture_idle", {31'd0, idle}, 32'd1);
      end
      default: start_capture(3, 1'b0);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;
    int post;
    reset = 1'b1; io_ready = 1'b0; io_rsp_valid = 1'b0; io_rsp_ok = 1'b0; io_rsp_status = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) tick();
    check("rst_sel", {28'd0, acsi_status_sel}, 32'd10);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_io_valid", {31'd0, io_valid}, 32'd0);
    check("rst_ack_nak", {30'd0, dma_ack, dma_nak}, 32'd0);
    check("rst_status", {24'd0, dma_status}, 32'd0);
    reset = 1'b0;
    tick();

    run_cmd(0, 1, 0, 1'b1, 8'h00, 2, 1);   // directed pattern, stale busy
    run_cmd(0, 0, 1, 1'b0, 8'h00, 0, 2);   // toggling ready, nak, chained next
    run_cmd(1, 0, 2, 1'b1, 8'h00, 1, 0);
    ch = 0;
    for (int i = 0; i < 6; i++) begin
      post = (i == 5) ? 0 : int'($urandom_range(0, 2));
      run_cmd(ch, 0, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              8'($urandom), int'($urandom_range(0, 5)), post);
      ch = (post == 2);
    end

    // Long wait: timeout fires, or the bridge keeps waiting.
    wait_idle();
    start_capture(0, 1'b0);
    send_phase(0);
`ifdef ACSI_IO_BRIDGE_TIMEOUT_EN
    begin
      cmp_t c;
      c.ok = 1'b0; c.st = 8'h02; c.at = cyc + 16;
      exp_cmp.push_back(c);
      last_st = 8'h02;
      repeat (17) tick();
      mem[10][0] = 1'b0;
    end
    // Response in the cycle the counter is all-ones wins.
    wait_idle();
    start_capture(0, 1'b0);
    send_phase(0);
    respond(15, 1'b1, 8'h33);
    mem[10][0] = 1'b0;
`else
    repeat (40) tick();
    check("wait_indefinitely", {31'd0, idle}, 32'd0);
    respond(0, 1'b1, 8'h33);
    mem[10][0] = 1'b0;
`endif

    // Reset in the middle of SEND with io_ready held low.
    wait_idle();
    start_capture(0, 1'b0);
    io_ready = 1'b0;
    for (int n = 0; n < 40 && !io_valid; n++) tick();
    check("send_reached", {31'd0, io_valid}, 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    mem[10][0] = 1'b0;
    tick();
    exp_bytes.delete();
    exp_first.delete();
    last_st = 8'h00;
    check("abort_idle", {31'd0, idle}, 32'd1);
    check("abort_io_valid", {31'd0, io_valid}, 32'd0);
    check("abort_status", {24'd0, dma_status}, 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("abort_no_pulse_idle", {31'd0, idle}, 32'd1);

    run_cmd(0, 0, 2, 1'b1, 8'hC1, 3, 0);
    repeat (6) tick();
    check("bytes_drained", exp_bytes.size(), 32'd0);
    check("valids_drained", exp_first.size(), 32'd0);
    check("completions_drained", exp_cmp.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
